pwm_gen: RTL and testbench
==========================

// Module: pwm_gen
// PURPOSE
//  Memory-mapped PWM generator; produces the single PWM waveform that the output-mode
//  stage muxes onto any led/opin pin whose mode bit is 1. Prescaled free-running counter,
//  programmable period/duty, double-buffered so register writes never glitch a running cycle.
// PARAMETERS
//  CNT_W   16  width of period/duty/counter
//  PRE_W   8   width of prescaler field/counter
// PORTS
//  clk    in   1      system clock, all state on rising edge
//  rst_n  in   1      asynchronous, active-low reset
//  A      in   2      register select: 0 CTRL, 1 PERIOD, 2 DUTY, 3 STATUS
//  WD     in   32     write data
//  WE     in   1      write strobe, register A written on clk edge when 1
//  RD     out  32     read data of register A, combinational, zero-extended
//  PWM    out  1      registered PWM output
//  irq    out  1      period-end interrupt (only with PWM_IRQ_EN)
// BEHAVIOUR
//  - Registers: CTRL[0]=EN, CTRL[8+:PRE_W]=PRESCALE; PERIOD[CNT_W-1:0]; DUTY[CNT_W-1:0];
//    STATUS[0]=running (=EN, read-only), STATUS[1]=done flag (PWM_IRQ_EN only). Unused bits read 0.
//  - Reset (async, rst_n=0): all registers, shadows, counters = 0; PWM=0; irq=0.
//  - Shadows per_a/duty_a: copied from PERIOD/DUTY while EN=0 and at every period boundary.
//  - EN=0: pre_cnt, cnt held at 0; PWM=0 next edge.
//  - EN=1: pre_cnt counts 0..PRESCALE; tick when pre_cnt==PRESCALE (pre_cnt->0).
//    On tick: if cnt==per_a -> boundary: cnt<=0, shadows reload; else cnt<=cnt+1.
//  - PWM <= EN && (cnt < duty_a), registered: one clk latency after counter state.
//  - Period = (PERIOD+1)*(PRESCALE+1) clk; high time = min(DUTY,PERIOD+1)*(PRESCALE+1).
//  - DUTY=0 -> PWM constantly 0; DUTY>PERIOD -> constantly 1 while EN.
//  - PERIOD=0 -> every tick is a boundary; PWM=1 iff duty_a>=1.
//  - PRESCALE change takes effect immediately (pre_cnt compares live value);
//    if pre_cnt>new PRESCALE, pre_cnt continues to wrap at 2^PRE_W then resumes.
//  - Write on same edge as boundary: shadows load the pre-write value; new value
//    applies at the following boundary.
//  - EN 1->0 mid-period: counters clear next edge, PWM=0 next edge; 0->1 restarts at cnt=0.
//  - Reset mid-operation: immediate clear, no partial period completed.
// CONFIGURATION
//  PWM_IRQ_EN defined: STATUS[1] set on each boundary; cleared by write to STATUS with
//    WD[1]=1; set wins over simultaneous clear; irq = STATUS[1] & CTRL[1] (IRQ enable bit).
//  PWM_IRQ_EN undefined: no irq port, STATUS[1] and CTRL[1] read 0, writes ignored.
// TESTING
//  - Reset: rst_n=0 mid-run with PWM=1 -> PWM, RD of all regs = 0 immediately.
//  - PERIOD=9, DUTY=3, PRESCALE=0, EN=1 -> PWM 3 clk high / 7 clk low, period 10 clk.
//  - PRESCALE=3, PERIOD=4, DUTY=2 -> 8 clk high / 12 clk low, period 20 clk.
//  - Edges: DUTY=0 -> PWM stays 0; DUTY=12 with PERIOD=9 -> PWM stays 1; PERIOD=0,DUTY=1 -> 1.
//  - Running PERIOD=9,DUTY=3; write DUTY=7 at cnt=5 -> current period still 3 high,
//    next period 7 high; write landing on boundary edge -> applies one period later.
//  - PWM_IRQ_EN, CTRL=0x3, PERIOD=4 -> irq rises every 5 clk; write STATUS=0x2 clears;
//    clear coincident with boundary -> flag stays 1.

Source files
------------

// File: rtl/pwm_gen_if.sv
// -----------------------------------------------------------------------------
// pwm_gen_if
// Register bus between a host and the PWM generator.
//   A   : register select (0 CTRL, 1 PERIOD, 2 DUTY, 3 STATUS)
//   WD  : write data
//   WE  : write strobe; register A is written on the clock edge while high
//   RD  : combinational read data of register A, zero-extended
// Modports: master (host side), slave (pwm_gen side).
// -----------------------------------------------------------------------------
interface pwm_gen_if;
    logic [1:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;

    modport master (output A, output WD, output WE, input RD);
    modport slave  (input A, input WD, input WE, output RD);
endinterface

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// Memory-mapped PWM generator. A free-running prescaler feeds a period counter;
// PERIOD and DUTY are double-buffered into shadows (per_a/duty_a) that only
// reload while disabled or at a period boundary, so register writes never
// disturb the cycle that is in progress.
//
// Ports
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : register bus (pwm_gen_if.slave)
//   PWM    : registered PWM output
//   irq    : period-end interrupt (present only when PWM_IRQ_EN is defined)
//
// Register map
//   0 CTRL   [0] EN, [1] IRQ enable (PWM_IRQ_EN only), [8+:PRE_W] PRESCALE
//   1 PERIOD [CNT_W-1:0]
//   2 DUTY   [CNT_W-1:0]
//   3 STATUS [0] running (= EN, read-only), [1] done flag (PWM_IRQ_EN only,
//            cleared by writing 1 to bit 1; a simultaneous boundary wins)
//
// Build option: define PWM_IRQ_EN to add the done flag, IRQ enable and irq port.
// -----------------------------------------------------------------------------
module pwm_gen #(
    parameter int CNT_W = 16,
    parameter int PRE_W = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    pwm_gen_if.slave  bus,
    output logic      PWM
`ifdef PWM_IRQ_EN
    ,
    output logic      irq
`endif
);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PERIOD = 2'd1,
        REG_DUTY   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    reg_sel_e          sel;
    logic              wr_ctrl;
    logic              wr_period;
    logic              wr_duty;

    // Programmer-visible registers
    logic              en;
    logic [PRE_W-1:0]  prescale;
    logic [CNT_W-1:0]  period_r;
    logic [CNT_W-1:0]  duty_r;

    // Shadows and counters
    logic [CNT_W-1:0]  per_a;
    logic [CNT_W-1:0]  duty_a;
    logic [PRE_W-1:0]  pre_cnt;
    logic [CNT_W-1:0]  cnt;
    logic              pwm_q;

    logic              tick;
    logic              boundary;
    logic              load_shadow;

`ifdef PWM_IRQ_EN
    logic              irq_en;
    logic              done;
    logic              wr_status;
`endif

    assign sel       = reg_sel_e'(bus.A);
    assign wr_ctrl   = bus.WE && (sel == REG_CTRL);
    assign wr_period = bus.WE && (sel == REG_PERIOD);
    assign wr_duty   = bus.WE && (sel == REG_DUTY);

    // Prescaler compares against the live PRESCALE value, so a change takes
    // effect immediately; if pre_cnt is already above the new value it simply
    // wraps through 2^PRE_W before matching again.
    assign tick        = en && (pre_cnt == prescale);
    assign boundary    = tick && (cnt == per_a);
    assign load_shadow = !en || boundary;

    // Register file
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values; this is what makes a write on a boundary
    // edge reach the shadows only one period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= 1'b0;
            prescale <= '0;
            period_r <= '0;
            duty_r   <= '0;
        end else begin
            if (wr_ctrl) begin
                en       <= bus.WD[0];
                prescale <= bus.WD[8 +: PRE_W];
            end
            if (wr_period) period_r <= bus.WD[CNT_W-1:0];
            if (wr_duty)   duty_r   <= bus.WD[CNT_W-1:0];
        end
    end

    // Prescaler, period counter, shadows and output flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            cnt     <= '0;
            per_a   <= '0;
            duty_a  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            if (!en) begin
                pre_cnt <= '0;
                cnt     <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
                cnt     <= boundary ? '0 : cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            if (load_shadow) begin
                per_a  <= period_r;
                duty_a <= duty_r;
            end

            // Output lags the counter by one clock; DUTY > PERIOD keeps it high.
            pwm_q <= en && (cnt < duty_a);
        end
    end

    assign PWM = pwm_q;

`ifdef PWM_IRQ_EN
    assign wr_status = bus.WE && (sel == REG_STATUS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= bus.WD[1];
            // Boundary set takes priority over a coincident software clear.
            if (boundary)                     done <= 1'b1;
            else if (wr_status && bus.WD[1])  done <= 1'b0;
        end
    end

    assign irq = done & irq_en;
`endif

    // Read mux
    // NOTE: rd_mux gets a full default before the case so no latch can be
    // inferred for bits or selects the case leaves untouched.
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        unique case (sel)
            REG_CTRL: begin
                rd_mux[0]          = en;
                rd_mux[8 +: PRE_W] = prescale;
`ifdef PWM_IRQ_EN
                rd_mux[1]          = irq_en;
`endif
            end
            REG_PERIOD: rd_mux[CNT_W-1:0] = period_r;
            REG_DUTY:   rd_mux[CNT_W-1:0] = duty_r;
            REG_STATUS: begin
                rd_mux[0] = en;
`ifdef PWM_IRQ_EN
                rd_mux[1] = done;
`endif
            end
            default: rd_mux = '0;
        endcase
    end

    assign bus.RD = rd_mux;

    // Only part of WD is decoded; fold the rest into a named sink.
    logic unused_wd;
    assign unused_wd = &{1'b0, bus.WD};

endmodule

// File: tb/tb_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_gen
// Self-checking bench for pwm_gen. Expected PWM levels come from the closed
// form of the waveform: period Tp = (PERIOD+1)*(PRESCALE+1) clocks, high for
// min(DUTY,PERIOD+1)*(PRESCALE+1) clocks at the start of each period, and a
// DUTY written at edge kw applies from the first period that begins after the
// first boundary edge strictly later than kw.
// -----------------------------------------------------------------------------
module tb_pwm_gen;

    localparam int CNT_W = 16;
    localparam int PRE_W = 8;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PERIOD = 2'd1;
    localparam logic [1:0] A_DUTY   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

`ifdef PWM_IRQ_EN
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF03;
    localparam logic [31:0] STAT_HI   = 32'h0000_0002;
    logic irq;
`else
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF01;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic pwm;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pwm_gen_if bus ();

    pwm_gen #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .PWM   (pwm)
`ifdef PWM_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge and
    // the task returns at the falling edge after it.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.A  = a;
        bus.WD = d;
        bus.WE = 1'b1;
        @(negedge clk);
        bus.WE = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.A = a;
        #1;
        check(tag, bus.RD, exp);
    endtask

    // Expected PWM at the k-th sample (k >= 1) after the enabling edge.
    function automatic logic model_pwm(int k, int p, int s, int d0, int d1, int kw);
        int tp;
        int n;
        int ph;
        int d;
        int hi;
        tp = (p + 1) * (s + 1);
        n  = (k - 1) / tp;
        ph = (k - 1) % tp;
        d  = (kw > 0 && n >= kw / tp + 1) ? d1 : d0;
        hi = ((d < p + 1) ? d : p + 1) * (s + 1);
        return ph < hi;
    endfunction

    // Disable, program, enable, then compare nk samples. A non-zero kw writes
    // DUTY=d1 on edge kw of the run.
    task automatic run_cfg(input string tag, input int p, input int s, input int d0,
                           input int d1, input int kw, input int nk);
        bus_write(A_CTRL, 32'h0);
        @(negedge clk);
        check({tag, "_off"}, {31'b0, pwm}, 32'h0);
        bus_write(A_PERIOD, 32'(p));
        bus_write(A_DUTY, 32'(d0));
        bus_write(A_CTRL, (32'(s) << 8) | 32'h1);
        check({tag, "_k0"}, {31'b0, pwm}, 32'h0);
        read_check({tag, "_stat"}, A_STATUS, 32'h1);
        for (int k = 1; k <= nk; k++) begin
            if (k == kw) begin
                bus.A  = A_DUTY;
                bus.WD = 32'(d1);
                bus.WE = 1'b1;
            end
            @(negedge clk);
            bus.WE = 1'b0;
            check(tag, {31'b0, pwm}, {31'b0, model_pwm(k, p, s, d0, d1, kw)});
        end
    endtask

    task automatic check_all_regs_zero(input string tag);
        read_check({tag, "_ctrl"}, A_CTRL, 32'h0);
        read_check({tag, "_per"},  A_PERIOD, 32'h0);
        read_check({tag, "_duty"}, A_DUTY, 32'h0);
        read_check({tag, "_stat"}, A_STATUS, 32'h0);
    endtask

    initial begin
        rst_n  = 1'b0;
        bus.A  = '0;
        bus.WD = '0;
        bus.WE = 1'b0;
        #12;
        check("rst_pwm", {31'b0, pwm}, 32'h0);
        check_all_regs_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Register readback with unused bits masked off
        for (int i = 0; i < 6; i++) begin
            logic [31:0] v;
            v = $urandom();
            bus_write(A_CTRL, v);
            read_check("rb_ctrl", A_CTRL, v & CTRL_MASK);
            read_check("rb_stat", A_STATUS, {31'b0, v[0]});
            v = $urandom();
            bus_write(A_PERIOD, v);
            read_check("rb_per", A_PERIOD, v & 32'h0000_FFFF);
            v = $urandom();
            bus_write(A_DUTY, v);
            read_check("rb_duty", A_DUTY, v & 32'h0000_FFFF);
        end

        // Directed waveforms
        run_cfg("p9d3",    9, 0, 3, 3, 0, 25);
        run_cfg("p4d2s3",  4, 3, 2, 2, 0, 45);
        run_cfg("duty0",   9, 0, 0, 0, 0, 25);
        run_cfg("duty12",  9, 0, 12, 12, 0, 25);
        run_cfg("p0d1",    0, 0, 1, 1, 0, 8);
        run_cfg("wr_mid",  9, 0, 3, 7, 6, 32);
        run_cfg("wr_bnd",  9, 0, 3, 7, 10, 32);

        // Randomized configurations, some with a mid-run DUTY write
        for (int t = 0; t < 24; t++) begin
            int p;
            int s;
            int d0;
            int d1;
            int tp;
            int kw;
            p  = int'($urandom_range(0, 12));
            s  = int'($urandom_range(0, 3));
            d0 = int'($urandom_range(0, 15));
            d1 = int'($urandom_range(0, 15));
            tp = (p + 1) * (s + 1);
            kw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * tp)) : 0;
            run_cfg("rand", p, s, d0, d1, kw, 3 * tp + 2);
        end

`ifdef PWM_IRQ_EN
        // Done flag / irq: boundaries every 5 clk; clear at k=7 works, clear
        // at k=15 coincides with a boundary and loses.
        begin
            logic done_exp;
            done_exp = 1'b0;
            bus_write(A_CTRL, 32'h0);
            bus_write(A_STATUS, STAT_HI);
            bus_write(A_PERIOD, 32'd4);
            bus_write(A_DUTY, 32'd2);
            bus_write(A_CTRL, 32'h3);
            for (int k = 1; k <= 22; k++) begin
                if (k == 7 || k == 15) begin
                    bus.A  = A_STATUS;
                    bus.WD = STAT_HI;
                    bus.WE = 1'b1;
                end
                @(negedge clk);
                bus.WE = 1'b0;
                if (k % 5 == 0)             done_exp = 1'b1;
                else if (k == 7 || k == 15) done_exp = 1'b0;
                check("irq", {31'b0, irq}, {31'b0, done_exp});
            end
            read_check("irq_stat", A_STATUS, {30'b0, done_exp, 1'b1});
        end
`endif

        // Asynchronous reset in the middle of a high phase
        run_cfg("pre_rst", 9, 0, 3, 3, 0, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pwm", {31'b0, pwm}, 32'h0);
        check_all_regs_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_pwm", {31'b0, pwm}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
